// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares one multi-digit seven-segment display between NUM_REQ requesters.
//   Valid sources are shown round-robin for DWELL_CYC cycles each; an urgent
//   pulse pins the display to that source for HOLD_CYC cycles.
//
// Optional build macro: SEG_ARB_SWITCH_FLASH_EN
//   When defined, all decimal points are lit for FLASH_CYC cycles after every
//   source switch (sel change, IDLE exit, HOLD entry/re-target).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req_valid    [NUM_REQ]                per-requester data-valid level
//   req_data     [NUM_REQ*NUM_SEGMENTS*4] per-requester digits, source i at
//                                         bits [i*NUM_SEGMENTS*4 +: NUM_SEGMENTS*4]
//   req_dp       [NUM_REQ*NUM_SEGMENTS]   per-requester decimal points, active-low
//   urgent       [NUM_REQ]                single-cycle preempt pulses
//   encoded      [NUM_SEGMENTS*4]         registered digits for seven_segment
//   digit_point  [NUM_SEGMENTS]           registered decimal points, active-low
//   grant        [NUM_REQ]                one-hot displayed source, zero in IDLE
//   hold_active                           high while in HOLD
module seg_display_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned NUM_SEGMENTS = 4,
   parameter int unsigned DWELL_CYC    = 200_000_000,
   parameter int unsigned HOLD_CYC     = 100_000_000,
   parameter int unsigned FLASH_CYC    = 25_000_000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*NUM_SEGMENTS*4-1:0] req_data,
   input  logic [NUM_REQ*NUM_SEGMENTS-1:0]   req_dp,
   input  logic [NUM_REQ-1:0]                urgent,
   output logic [NUM_SEGMENTS*4-1:0]         encoded,
   output logic [NUM_SEGMENTS-1:0]           digit_point,
   output logic [NUM_REQ-1:0]                grant,
   output logic                              hold_active
);

   localparam int unsigned DW      = NUM_SEGMENTS * 4;
   localparam int unsigned SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_MAX = (DWELL_CYC > HOLD_CYC) ? DWELL_CYC : HOLD_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_SEGMENTS < 1 ||
       DWELL_CYC < 1 || HOLD_CYC < 1 || FLASH_CYC < 1) begin : g_bad_param
      $error("seg_display_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [SEL_W-1:0]    r_sel, w_sel_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

   logic                w_any_valid;
   logic [SEL_W-1:0]    w_low_valid;
   logic [SEL_W-1:0]    w_low_urgent;
   logic [SEL_W-1:0]    w_rr_next;
   logic [2*NUM_REQ-1:0] w_rot;
   logic [NUM_REQ-1:0]  w_grant_nxt;
   logic                w_flash_force;

   logic [DW-1:0]           r_encoded;
   logic [NUM_SEGMENTS-1:0] r_dp;
   logic [NUM_REQ-1:0]      r_grant;

   // Lowest-index searches: iterate downward so the last hit is the lowest.
   always_comb begin
      w_any_valid  = |req_valid;
      w_low_valid  = '0;
      w_low_urgent = '0;
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         if (req_valid[i-1]) w_low_valid  = SEL_W'(i-1);
         if (urgent[i-1])    w_low_urgent = SEL_W'(i-1);
      end
   end

   // Round-robin: rotate a doubled copy of req_valid so bit j is the source
   // j+1 places after sel; the lowest hit (searched downward) wins, and bit
   // NUM_REQ-1 wraps back to sel itself.
   always_comb begin
      w_rot     = {req_valid, req_valid} >> (32'(r_sel) + 32'd1);
      w_rr_next = r_sel;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         if (w_rot[k-1]) w_rr_next = SEL_W'((32'(r_sel) + k) % NUM_REQ);
      end
   end

   // Next-state logic; priority is urgent > valid-drop > dwell/hold expiry.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      if (urgent != '0) begin
         w_state_nxt = ST_HOLD;
         w_sel_nxt   = w_low_urgent;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_cnt_nxt = '0;
               if (w_any_valid) begin
                  w_state_nxt = ST_SHOW;
                  w_sel_nxt   = w_low_valid;
               end
            end
            ST_SHOW: begin
               if (!req_valid[r_sel]) begin
                  w_cnt_nxt = '0;
                  if (w_any_valid) w_sel_nxt   = w_rr_next;
                  else             w_state_nxt = ST_IDLE;
               end else if (r_cnt == CNT_W'(DWELL_CYC - 1)) begin
                  w_cnt_nxt = '0;
                  w_sel_nxt = w_rr_next;
               end
            end
            ST_HOLD: begin
               if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                  w_cnt_nxt = '0;
                  if (req_valid[r_sel]) begin
                     w_state_nxt = ST_SHOW;
                  end else if (w_any_valid) begin
                     w_state_nxt = ST_SHOW;
                     w_sel_nxt   = w_rr_next;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_sel_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef SEG_ARB_SWITCH_FLASH_EN
   localparam int unsigned FL_W = $clog2(FLASH_CYC + 1);

   logic [FL_W-1:0] r_flash, w_flash_nxt;
   logic            w_switch;

   // r_flash holds the flash cycles still to show, including the one being
   // registered now, so a load of FLASH_CYC lights the DPs exactly that long.
   always_comb begin
      w_switch = (w_state_nxt != ST_IDLE) &&
                 ((w_sel_nxt != r_sel) || (r_state == ST_IDLE) || (urgent != '0));
      if (w_state_nxt == ST_IDLE) w_flash_nxt = '0;
      else if (w_switch)          w_flash_nxt = FL_W'(FLASH_CYC);
      else if (r_flash != '0)     w_flash_nxt = r_flash - FL_W'(1);
      else                        w_flash_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) r_flash <= '0;
      else       r_flash <= w_flash_nxt;
   end

   assign w_flash_force = (w_flash_nxt != '0);
`else
   assign w_flash_force = 1'b0;
`endif

   always_comb begin
      w_grant_nxt            = '0;
      w_grant_nxt[w_sel_nxt] = 1'b1;
   end

   // Outputs are registered from the next-state values so grant, encoded and
   // hold_active always describe the same source in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || (w_state_nxt == ST_IDLE)) begin
         r_encoded <= '0;
         r_dp      <= '1;
         r_grant   <= '0;
      end else begin
         r_encoded <= req_data[32'(w_sel_nxt)*DW +: DW];
         r_dp      <= w_flash_force ? '0 : req_dp[32'(w_sel_nxt)*NUM_SEGMENTS +: NUM_SEGMENTS];
         r_grant   <= w_grant_nxt;
      end
   end

   assign encoded     = r_encoded;
   assign digit_point = r_dp;
   assign grant       = r_grant;
   assign hold_active = (r_state == ST_HOLD);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter
//   Directed-vector bench for seg_display_arbiter with NUM_REQ=4,
//   NUM_SEGMENTS=4, DWELL_CYC=8, HOLD_CYC=5, FLASH_CYC=3. Inputs change 1 ns
//   after each rising edge; outputs are checked at that same point.
//   Honours SEG_ARB_SWITCH_FLASH_EN when it is defined for the build.
module tb_seg_display_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [15:0] req_dp;
   logic [3:0]  urgent;
   logic [15:0] encoded;
   logic [3:0]  digit_point;
   logic [3:0]  grant;
   logic        hold_active;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

`ifdef SEG_ARB_SWITCH_FLASH_EN
   localparam bit FLASH = 1'b1;
`else
   localparam bit FLASH = 1'b0;
`endif

   seg_display_arbiter #(
      .NUM_REQ      (4),
      .NUM_SEGMENTS (4),
      .DWELL_CYC    (8),
      .HOLD_CYC     (5),
      .FLASH_CYC    (3)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_dp      (req_dp),
      .urgent      (urgent),
      .encoded     (encoded),
      .digit_point (digit_point),
      .grant       (grant),
      .hold_active (hold_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      urgent    = '0;
      step();
      reset     = 1'b0;
   endtask

   logic [15:0] data_of [4];
   logic [3:0]  dp_of   [4];

   initial begin
      data_of[0] = 16'h1234; dp_of[0] = 4'hE;
      data_of[1] = 16'h9876; dp_of[1] = 4'h7;
      data_of[2] = 16'hABCD; dp_of[2] = 4'hB;
      data_of[3] = 16'h5678; dp_of[3] = 4'hD;
      for (int i = 0; i < 4; i++) begin
         req_data[i*16 +: 16] = data_of[i];
         req_dp[i*4 +: 4]     = dp_of[i];
      end

      // reset state and idle with nothing valid
      do_reset();
      check("rst_enc",  32'(encoded), 32'h0);
      check("rst_dp",   32'(digit_point), 32'hF);
      check("rst_gnt",  32'(grant), 32'h0);
      check("rst_hold", 32'(hold_active), 32'h0);
      for (int k = 0; k < 20; k++) begin
         step();
         check("idle_enc", 32'(encoded), 32'h0);
         check("idle_dp",  32'(digit_point), 32'hF);
         check("idle_gnt", 32'(grant), 32'h0);
      end

      // round-robin between sources 0 and 2, 8 cycles each
      req_valid = 4'b0101;
      for (int k = 0; k < 24; k++) begin
         int s;
         logic [3:0] edp;
         step();
         s   = ((k / 8) % 2 == 0) ? 0 : 2;
         edp = (FLASH && (k % 8) < 3) ? 4'h0 : dp_of[s];
         check("rr_gnt", 32'(grant), 32'(1 << s));
         check("rr_enc", 32'(encoded), 32'(data_of[s]));
         check("rr_dp",  32'(digit_point), 32'(edp));
         check("rr_hold", 32'(hold_active), 32'h0);
      end

      // valid drop moves to the next valid source, then IDLE when none remain
      do_reset();
      req_valid = 4'b0001;
      step();
      check("drop_gnt0", 32'(grant), 32'h1);
      step();
      req_valid = 4'b1000;
      step();
      check("drop_gnt3", 32'(grant), 32'h8);
      check("drop_enc3", 32'(encoded), 32'h5678);
      req_valid = 4'b0000;
      step();
      check("drop_idle_gnt", 32'(grant), 32'h0);
      check("drop_idle_enc", 32'(encoded), 32'h0);
      check("drop_idle_dp",  32'(digit_point), 32'hF);

      // urgent preempts for 5 cycles, then a full dwell on the urgent source
      do_reset();
      req_valid = 4'b0111;
      step();
      check("urg_pre_gnt", 32'(grant), 32'h1);
      step();
      urgent = 4'b0110;
      step();
      urgent = 4'b0000;
      check("urg_enc", 32'(encoded), 32'h9876);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         check("urg_hold", 32'(hold_active), 32'h1);
         check("urg_gnt",  32'(grant), 32'h2);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         check("urg_show_hold", 32'(hold_active), 32'h0);
         check("urg_show_gnt",  32'(grant), 32'h2);
      end
      step();
      check("urg_next_gnt", 32'(grant), 32'h4);

      // re-targeting and restarting the hold, urgent source not valid
      do_reset();
      req_valid = 4'b0001;
      step();
      urgent = 4'b0010;
      step();
      urgent = 4'b0000;
      check("rt_hold1", 32'(hold_active), 32'h1);
      check("rt_gnt1",  32'(grant), 32'h2);
      step();
      step();
      urgent = 4'b1000;
      step();
      urgent = 4'b0000;
      check("rt_gnt3", 32'(grant), 32'h8);
      check("rt_hold3", 32'(hold_active), 32'h1);
      step();
      urgent = 4'b1000;
      step();
      urgent = 4'b0000;
      check("rt_enc3", 32'(encoded), 32'h5678);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         check("rt_hold_last", 32'(hold_active), 32'h1);
         check("rt_gnt_last",  32'(grant), 32'h8);
      end
      step();
      check("rt_end_hold", 32'(hold_active), 32'h0);
      check("rt_end_gnt",  32'(grant), 32'h1);
      check("rt_end_enc",  32'(encoded), 32'h1234);

      // reset in the middle of a hold leaves nothing behind
      do_reset();
      urgent = 4'b0100;
      step();
      urgent = 4'b0000;
      check("rh_hold", 32'(hold_active), 32'h1);
      check("rh_gnt",  32'(grant), 32'h4);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rh_rst_hold", 32'(hold_active), 32'h0);
      check("rh_rst_gnt",  32'(grant), 32'h0);
      check("rh_rst_enc",  32'(encoded), 32'h0);
      check("rh_rst_dp",   32'(digit_point), 32'hF);
      for (int k = 0; k < 3; k++) begin
         step();
         check("rh_idle_hold", 32'(hold_active), 32'h0);
         check("rh_idle_gnt",  32'(grant), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
